strassen_run_sequencer: RTL and testbench

- Synthesizable run controller that replaces hand-sequenced start/mode/wait-done stimulus for the Strassen top.
- Steps through a parametrised list of matrix-size modes, pulses start for each, waits for done with a timeout, and streams the valid C sub-block into a checksum.
- Compares each checksum against an expected value and keeps pass/fail/timeout status.
- Sits between the test controller (or on-board self-test) and topStrassen.

---
 rtl/strassen_run_sequencer.sv | 250 +++++++++++++++++++++++++
 tb/tb_strassen_run_sequencer.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/strassen_run_sequencer.sv
// strassen_run_sequencer
// Run controller for topStrassen. Walks a list of matrix-size modes, pulses
// start for each valid entry, waits for done (with a timeout), sums the
// valid C sub-block row-major and compares the sum against an expected
// checksum. Pass/fail/timeout status is kept until the next accepted go.
//
// Ports:
//   clk, reset      : rising-edge clock, asynchronous active-high reset
//   go              : one-cycle request to run the whole list (ignored while busy)
//   mode_list       : entry k at [4k+:4], run order k=0 first
//   exp_sum         : expected checksum for entry k at [CS_W*k+:CS_W]
//   dut_mode        : mode driven to topStrassen (holds between tests)
//   dut_start       : one-cycle start pulse
//   dut_done        : done from topStrassen
//   dut_c           : C bus, element (r,c) at [(r*N_MAX+c)*DATA_W+:DATA_W]
//   busy, all_done  : run in progress / one-cycle completion pulse
//   test_idx        : index of the current test
//   cur_sum         : last computed checksum
//   pass_cnt, fail_cnt, timeout_flag, first_fail_idx : run status
//   lat_max         : only with STRASSEN_SEQ_LAT_EN defined; largest
//                     START-to-accepted-done latency, saturating at 16 bits
//
// Optional feature macro: STRASSEN_SEQ_LAT_EN
module strassen_run_sequencer #(
  parameter int DATA_W      = 12,
  parameter int N_MAX       = 8,
  parameter int NUM_TESTS   = 3,
  parameter int TIMEOUT_CYC = 4096,
  parameter int GAP_CYC     = 2,
  parameter int CS_W        = DATA_W + 2 * $clog2(N_MAX)
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              go,
  input  logic [4*NUM_TESTS-1:0]            mode_list,
  input  logic [CS_W*NUM_TESTS-1:0]         exp_sum,
  output logic [3:0]                        dut_mode,
  output logic                              dut_start,
  input  logic                              dut_done,
  input  logic [N_MAX*N_MAX*DATA_W-1:0]     dut_c,
  output logic                              busy,
  output logic                              all_done,
  output logic [$clog2(NUM_TESTS+1)-1:0]    test_idx,
  output logic [CS_W-1:0]                   cur_sum,
  output logic [$clog2(NUM_TESTS+1)-1:0]    pass_cnt,
  output logic [$clog2(NUM_TESTS+1)-1:0]    fail_cnt,
  output logic                              timeout_flag,
  output logic [$clog2(NUM_TESTS+1)-1:0]    first_fail_idx
`ifdef STRASSEN_SEQ_LAT_EN
  ,
  output logic [15:0]                       lat_max
`endif
);

  localparam int IDX_W = $clog2(NUM_TESTS + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYC);
  localparam int GAP_W = $clog2(GAP_CYC + 1);
  localparam int EL_W  = $clog2(N_MAX * N_MAX);

  localparam logic [IDX_W-1:0] NO_FAIL  = IDX_W'(NUM_TESTS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TESTS - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_START, S_WAIT, S_SUM, S_CHECK, S_GAP, S_FINISH
  } state_t;

  state_t            state;
  logic              armed;
  logic [TO_W-1:0]   wait_cnt;
  logic [GAP_W-1:0]  gap_cnt;
  logic [3:0]        row;
  logic [3:0]        col;
  logic [CS_W-1:0]   sum;

  logic [3:0]        mode_arr [NUM_TESTS];
  logic [CS_W-1:0]   exp_arr  [NUM_TESTS];
  logic [DATA_W-1:0] c_arr    [N_MAX*N_MAX];

  logic [3:0]        cur_mode;
  logic              mode_ok;
  logic [EL_W-1:0]   elem_sel;

  for (genvar k = 0; k < NUM_TESTS; k++) begin : g_list
    assign mode_arr[k] = mode_list[4*k +: 4];
    assign exp_arr[k]  = exp_sum[CS_W*k +: CS_W];
  end

  for (genvar e = 0; e < N_MAX * N_MAX; e++) begin : g_cbus
    assign c_arr[e] = dut_c[e*DATA_W +: DATA_W];
  end

  // Only powers of two from 2 up to N_MAX are sizes topStrassen can run.
  assign cur_mode = mode_arr[test_idx];
  assign mode_ok  = (cur_mode >= 4'd2) && (int'(cur_mode) <= N_MAX) &&
                    ((cur_mode & (cur_mode - 4'd1)) == 4'd0);

  // Row-major walk over the valid sub-block of the full N_MAX-wide C bus.
  assign elem_sel = EL_W'(row) * EL_W'(N_MAX) + EL_W'(col);

`ifdef STRASSEN_SEQ_LAT_EN
  // The START cycle counts as cycle 0, so the latency at acceptance is the
  // number of WAIT cycles already spent plus one.
  logic [31:0] lat_now;
  logic [15:0] lat_cand;

  assign lat_now = 32'(wait_cnt) + 32'd1;

  always_comb begin
    lat_cand = lat_now[15:0];
    if (lat_now > 32'h0000_FFFF) lat_cand = 16'hFFFF;
  end
`endif

  // Main sequencer. All outputs are registered here; dut_start is high only
  // while in START, all_done only while in FINISH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= S_IDLE;
      dut_mode       <= '0;
      dut_start      <= 1'b0;
      busy           <= 1'b0;
      all_done       <= 1'b0;
      test_idx       <= '0;
      cur_sum        <= '0;
      pass_cnt       <= '0;
      fail_cnt       <= '0;
      timeout_flag   <= 1'b0;
      first_fail_idx <= NO_FAIL;
      armed          <= 1'b0;
      wait_cnt       <= '0;
      gap_cnt        <= '0;
      row            <= '0;
      col            <= '0;
      sum            <= '0;
`ifdef STRASSEN_SEQ_LAT_EN
      lat_max        <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (go) begin
            pass_cnt       <= '0;
            fail_cnt       <= '0;
            timeout_flag   <= 1'b0;
            first_fail_idx <= NO_FAIL;
            test_idx       <= '0;
            busy           <= 1'b1;
`ifdef STRASSEN_SEQ_LAT_EN
            lat_max        <= '0;
`endif
            state          <= S_LOAD;
          end
        end

        S_LOAD: begin
          dut_mode <= cur_mode;
          if (mode_ok) begin
            dut_start <= 1'b1;
            state     <= S_START;
          end else begin
            // Unrunnable size: record a fail without ever starting the DUT.
            fail_cnt <= fail_cnt + IDX_W'(1);
            if (first_fail_idx == NO_FAIL) first_fail_idx <= test_idx;
            gap_cnt  <= '0;
            state    <= S_GAP;
          end
        end

        S_START: begin
          dut_start <= 1'b0;
          armed     <= 1'b0;
          wait_cnt  <= '0;
          state     <= S_WAIT;
        end

        S_WAIT: begin
          // Done must be seen low once before it is trusted, so a done left
          // high by the previous run cannot end this one.
          if (!dut_done) armed <= 1'b1;
          if (dut_done && armed) begin
            row   <= '0;
            col   <= '0;
            sum   <= '0;
            state <= S_SUM;
`ifdef STRASSEN_SEQ_LAT_EN
            if (lat_cand > lat_max) lat_max <= lat_cand;
`endif
          end else if (wait_cnt == TO_LAST) begin
            timeout_flag <= 1'b1;
            fail_cnt     <= fail_cnt + IDX_W'(1);
            if (first_fail_idx == NO_FAIL) first_fail_idx <= test_idx;
            gap_cnt      <= '0;
            state        <= S_GAP;
          end else begin
            wait_cnt <= wait_cnt + TO_W'(1);
          end
        end

        S_SUM: begin
          // C is sampled live; the DUT keeps it stable after done.
          sum <= sum + CS_W'(c_arr[elem_sel]);
          if (col == dut_mode - 4'd1) begin
            col <= '0;
            if (row == dut_mode - 4'd1) state <= S_CHECK;
            else                        row   <= row + 4'd1;
          end else begin
            col <= col + 4'd1;
          end
        end

        S_CHECK: begin
          cur_sum <= sum;
          if (sum == exp_arr[test_idx]) begin
            pass_cnt <= pass_cnt + IDX_W'(1);
          end else begin
            fail_cnt <= fail_cnt + IDX_W'(1);
            if (first_fail_idx == NO_FAIL) first_fail_idx <= test_idx;
          end
          gap_cnt <= '0;
          state   <= S_GAP;
        end

        S_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            if (test_idx == LAST_IDX) begin
              all_done <= 1'b1;
              busy     <= 1'b0;
              state    <= S_FINISH;
            end else begin
              test_idx <= test_idx + IDX_W'(1);
              state    <= S_LOAD;
            end
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end

        S_FINISH: begin
          all_done <= 1'b0;
          state    <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_strassen_run_sequencer.sv
// tb_strassen_run_sequencer
// Directed bench for strassen_run_sequencer with a small topStrassen model
// that raises done a fixed number of cycles after start and holds it until
// the next start. All C elements are 1, so a mode-m test sums to m*m.
module tb_strassen_run_sequencer;

  localparam int DATA_W    = 12;
  localparam int N_MAX     = 8;
  localparam int NUM_TESTS = 3;
  localparam int CS_W      = DATA_W + 2 * $clog2(N_MAX);
  localparam int MODEL_LAT = 10;

  logic                          clk = 1'b0;
  logic                          reset;
  logic                          go;
  logic [4*NUM_TESTS-1:0]        mode_list;
  logic [CS_W*NUM_TESTS-1:0]     exp_sum;
  logic [3:0]                    dut_mode;
  logic                          dut_start;
  logic                          dut_done;
  logic [N_MAX*N_MAX*DATA_W-1:0] dut_c;
  logic                          busy;
  logic                          all_done;
  logic [1:0]                    test_idx;
  logic [CS_W-1:0]               cur_sum;
  logic [1:0]                    pass_cnt;
  logic [1:0]                    fail_cnt;
  logic                          timeout_flag;
  logic [1:0]                    first_fail_idx;
`ifdef STRASSEN_SEQ_LAT_EN
  logic [15:0]                   lat_max;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  // topStrassen model
  int   model_cnt  = 0;
  logic model_done = 1'b0;
  bit   hang       = 1'b0;

  // monitor
  int         start_cnt   = 0;
  int         done_pulses = 0;
  logic [3:0] start_modes[$];

  strassen_run_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .go            (go),
    .mode_list     (mode_list),
    .exp_sum       (exp_sum),
    .dut_mode      (dut_mode),
    .dut_start     (dut_start),
    .dut_done      (dut_done),
    .dut_c         (dut_c),
    .busy          (busy),
    .all_done      (all_done),
    .test_idx      (test_idx),
    .cur_sum       (cur_sum),
    .pass_cnt      (pass_cnt),
    .fail_cnt      (fail_cnt),
    .timeout_flag  (timeout_flag),
    .first_fail_idx(first_fail_idx)
`ifdef STRASSEN_SEQ_LAT_EN
    ,
    .lat_max       (lat_max)
`endif
  );

  always #5 clk = ~clk;

  assign dut_done = model_done;

  // Done rises MODEL_LAT cycles after the START cycle and stays high until
  // the next start; while hang is set the model ignores starts entirely.
  always @(posedge clk) begin
    if (dut_start && !hang) begin
      model_cnt  <= 1;
      model_done <= 1'b0;
    end else if (model_cnt != 0) begin
      if (model_cnt == MODEL_LAT - 1) begin
        model_done <= 1'b1;
        model_cnt  <= 0;
      end else begin
        model_cnt <= model_cnt + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (dut_start) begin
      start_cnt <= start_cnt + 1;
      start_modes.push_back(dut_mode);
    end
    if (all_done) done_pulses <= done_pulses + 1;
  end

  task automatic pulse_go();
    @(negedge clk);
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
  endtask

  task automatic wait_all_done(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (all_done) seen = 1'b1;
    end
  endtask

  task automatic wait_start(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (dut_start) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    go    = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (busy !== 1'b0) $display("[TB] FAIL reset busy got %0b expected 0", busy); else n_pass++;
    n_checks++; if (dut_start !== 1'b0) $display("[TB] FAIL reset dut_start got %0b expected 0", dut_start); else n_pass++;
    n_checks++; if (first_fail_idx !== 2'd3) $display("[TB] FAIL reset first_fail_idx got %0d expected 3", first_fail_idx); else n_pass++;
    n_checks++;
    if ({all_done, timeout_flag, dut_mode, test_idx, pass_cnt, fail_cnt, cur_sum} !== '0)
      $display("[TB] FAIL reset zero_outputs got done=%0b to=%0b mode=%0d idx=%0d p=%0d f=%0d sum=%0d expected all 0",
               all_done, timeout_flag, dut_mode, test_idx, pass_cnt, fail_cnt, cur_sum);
    else n_pass++;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (busy !== 1'b0) $display("[TB] FAIL idle busy got %0b expected 0", busy); else n_pass++;
  endtask

  task automatic test_nominal();
    int  base;
    int  dbase;
    bit  seen;
    mode_list = {4'd8, 4'd4, 4'd2};
    exp_sum   = {18'd64, 18'd16, 18'd4};
    base  = start_modes.size();
    dbase = done_pulses;
    pulse_go();
    n_checks++; if (busy !== 1'b1) $display("[TB] FAIL nominal busy_after_go got %0b expected 1", busy); else n_pass++;
    wait_all_done(500, seen);
    n_checks++; if (seen !== 1'b1) $display("[TB] FAIL nominal all_done_seen got %0b expected 1", seen); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("[TB] FAIL nominal busy_at_all_done got %0b expected 0", busy); else n_pass++;
    @(negedge clk);
    n_checks++; if (all_done !== 1'b0) $display("[TB] FAIL nominal all_done_width got %0b expected 0", all_done); else n_pass++;
    repeat (3) @(negedge clk);
    n_checks++; if (start_modes.size() - base !== 3) $display("[TB] FAIL nominal start_count got %0d expected 3", start_modes.size() - base); else n_pass++;
    if (start_modes.size() - base == 3) begin
      n_checks++; if (start_modes[base] !== 4'd2) $display("[TB] FAIL nominal mode0 got %0d expected 2", start_modes[base]); else n_pass++;
      n_checks++; if (start_modes[base+1] !== 4'd4) $display("[TB] FAIL nominal mode1 got %0d expected 4", start_modes[base+1]); else n_pass++;
      n_checks++; if (start_modes[base+2] !== 4'd8) $display("[TB] FAIL nominal mode2 got %0d expected 8", start_modes[base+2]); else n_pass++;
    end
    n_checks++; if (done_pulses - dbase !== 1) $display("[TB] FAIL nominal all_done_pulses got %0d expected 1", done_pulses - dbase); else n_pass++;
    n_checks++; if (pass_cnt !== 2'd3) $display("[TB] FAIL nominal pass_cnt got %0d expected 3", pass_cnt); else n_pass++;
    n_checks++; if (fail_cnt !== 2'd0) $display("[TB] FAIL nominal fail_cnt got %0d expected 0", fail_cnt); else n_pass++;
    n_checks++; if (first_fail_idx !== 2'd3) $display("[TB] FAIL nominal first_fail_idx got %0d expected 3", first_fail_idx); else n_pass++;
    n_checks++; if (cur_sum !== 18'd64) $display("[TB] FAIL nominal cur_sum got %0d expected 64", cur_sum); else n_pass++;
    n_checks++; if (dut_mode !== 4'd8) $display("[TB] FAIL nominal dut_mode_hold got %0d expected 8", dut_mode); else n_pass++;
`ifdef STRASSEN_SEQ_LAT_EN
    n_checks++; if (lat_max !== 16'd10) $display("[TB] FAIL nominal lat_max got %0d expected 10", lat_max); else n_pass++;
`endif
  endtask

  task automatic test_mismatch();
    bit seen;
    mode_list = {4'd8, 4'd4, 4'd2};
    exp_sum   = {18'd64, 18'd17, 18'd4};
    pulse_go();
    wait_all_done(500, seen);
    n_checks++; if (seen !== 1'b1) $display("[TB] FAIL mismatch all_done_seen got %0b expected 1", seen); else n_pass++;
    @(negedge clk);
    n_checks++; if (pass_cnt !== 2'd2) $display("[TB] FAIL mismatch pass_cnt got %0d expected 2", pass_cnt); else n_pass++;
    n_checks++; if (fail_cnt !== 2'd1) $display("[TB] FAIL mismatch fail_cnt got %0d expected 1", fail_cnt); else n_pass++;
    n_checks++; if (first_fail_idx !== 2'd1) $display("[TB] FAIL mismatch first_fail_idx got %0d expected 1", first_fail_idx); else n_pass++;
    n_checks++; if (cur_sum !== 18'd64) $display("[TB] FAIL mismatch cur_sum got %0d expected 64", cur_sum); else n_pass++;
    n_checks++; if (timeout_flag !== 1'b0) $display("[TB] FAIL mismatch timeout_flag got %0b expected 0", timeout_flag); else n_pass++;
  endtask

  // done is still high from the previous run; the model ignores test 0's
  // start, so test 0 must time out after 4096 WAIT cycles.
  task automatic test_timeout();
    int base;
    int cyc;
    bit seen;
    mode_list = {4'd8, 4'd4, 4'd2};
    exp_sum   = {18'd64, 18'd16, 18'd4};
    hang = 1'b1;
    base = start_modes.size();
    pulse_go();
    wait_start(20, seen);
    n_checks++; if (seen !== 1'b1) $display("[TB] FAIL timeout first_start got %0b expected 1", seen); else n_pass++;
    cyc  = 0;
    seen = 1'b0;
    for (int i = 0; i < 5000 && !seen; i++) begin
      @(negedge clk);
      cyc++;
      if (timeout_flag) seen = 1'b1;
    end
    hang = 1'b0;
    n_checks++; if (seen !== 1'b1) $display("[TB] FAIL timeout flag_seen got %0b expected 1", seen); else n_pass++;
    n_checks++; if (cyc !== 4097) $display("[TB] FAIL timeout start_to_flag_cycles got %0d expected 4097", cyc); else n_pass++;
    wait_all_done(500, seen);
    n_checks++; if (seen !== 1'b1) $display("[TB] FAIL timeout all_done_seen got %0b expected 1", seen); else n_pass++;
    repeat (2) @(negedge clk);
    n_checks++; if (timeout_flag !== 1'b1) $display("[TB] FAIL timeout timeout_flag_sticky got %0b expected 1", timeout_flag); else n_pass++;
    n_checks++; if (fail_cnt !== 2'd1) $display("[TB] FAIL timeout fail_cnt got %0d expected 1", fail_cnt); else n_pass++;
    n_checks++; if (pass_cnt !== 2'd2) $display("[TB] FAIL timeout pass_cnt got %0d expected 2", pass_cnt); else n_pass++;
    n_checks++; if (first_fail_idx !== 2'd0) $display("[TB] FAIL timeout first_fail_idx got %0d expected 0", first_fail_idx); else n_pass++;
    n_checks++; if (start_modes.size() - base !== 3) $display("[TB] FAIL timeout start_count got %0d expected 3", start_modes.size() - base); else n_pass++;
  endtask

  task automatic test_invalid_mode();
    int base;
    bit seen;
    mode_list = {4'd8, 4'd3, 4'd2};
    exp_sum   = {18'd64, 18'd9, 18'd4};
    base = start_modes.size();
    pulse_go();
    wait_all_done(500, seen);
    n_checks++; if (seen !== 1'b1) $display("[TB] FAIL invalid all_done_seen got %0b expected 1", seen); else n_pass++;
    repeat (2) @(negedge clk);
    n_checks++; if (start_modes.size() - base !== 2) $display("[TB] FAIL invalid start_count got %0d expected 2", start_modes.size() - base); else n_pass++;
    if (start_modes.size() - base == 2) begin
      n_checks++; if (start_modes[base+1] !== 4'd8) $display("[TB] FAIL invalid second_start_mode got %0d expected 8", start_modes[base+1]); else n_pass++;
    end
    n_checks++; if (fail_cnt !== 2'd1) $display("[TB] FAIL invalid fail_cnt got %0d expected 1", fail_cnt); else n_pass++;
    n_checks++; if (pass_cnt !== 2'd2) $display("[TB] FAIL invalid pass_cnt got %0d expected 2", pass_cnt); else n_pass++;
    n_checks++; if (first_fail_idx !== 2'd1) $display("[TB] FAIL invalid first_fail_idx got %0d expected 1", first_fail_idx); else n_pass++;
    n_checks++; if (timeout_flag !== 1'b0) $display("[TB] FAIL invalid timeout_flag got %0b expected 0", timeout_flag); else n_pass++;
  endtask

  task automatic test_busy_reset();
    int base;
    bit seen;
    mode_list = {4'd8, 4'd4, 4'd2};
    exp_sum   = {18'd64, 18'd16, 18'd4};
    base = start_modes.size();
    pulse_go();
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (test_idx == 2'd1) seen = 1'b1;
    end
    n_checks++; if (seen !== 1'b1) $display("[TB] FAIL busy reach_test1 got %0b expected 1", seen); else n_pass++;
    pulse_go();
    n_checks++; if (test_idx !== 2'd1) $display("[TB] FAIL busy go_ignored_idx got %0d expected 1", test_idx); else n_pass++;
    n_checks++; if (busy !== 1'b1) $display("[TB] FAIL busy go_ignored_busy got %0b expected 1", busy); else n_pass++;
    wait_all_done(500, seen);
    n_checks++; if (seen !== 1'b1) $display("[TB] FAIL busy all_done_seen got %0b expected 1", seen); else n_pass++;
    repeat (2) @(negedge clk);
    n_checks++; if (pass_cnt !== 2'd3) $display("[TB] FAIL busy pass_cnt got %0d expected 3", pass_cnt); else n_pass++;
    n_checks++; if (start_modes.size() - base !== 3) $display("[TB] FAIL busy start_count got %0d expected 3", start_modes.size() - base); else n_pass++;

    // reset while test 1 is waiting for done
    pulse_go();
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (test_idx == 2'd1 && dut_start) seen = 1'b1;
    end
    n_checks++; if (seen !== 1'b1) $display("[TB] FAIL busy reach_start1 got %0b expected 1", seen); else n_pass++;
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    n_checks++; if (busy !== 1'b0) $display("[TB] FAIL busy reset_busy got %0b expected 0", busy); else n_pass++;
    n_checks++; if (pass_cnt !== 2'd0) $display("[TB] FAIL busy reset_pass_cnt got %0d expected 0", pass_cnt); else n_pass++;
    n_checks++; if (first_fail_idx !== 2'd3) $display("[TB] FAIL busy reset_first_fail_idx got %0d expected 3", first_fail_idx); else n_pass++;
    n_checks++; if (dut_mode !== 4'd0) $display("[TB] FAIL busy reset_dut_mode got %0d expected 0", dut_mode); else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    pulse_go();
    wait_start(20, seen);
    n_checks++; if (seen !== 1'b1) $display("[TB] FAIL busy restart_start got %0b expected 1", seen); else n_pass++;
    n_checks++; if (test_idx !== 2'd0) $display("[TB] FAIL busy restart_idx got %0d expected 0", test_idx); else n_pass++;
    n_checks++; if (dut_mode !== 4'd2) $display("[TB] FAIL busy restart_mode got %0d expected 2", dut_mode); else n_pass++;
    wait_all_done(500, seen);
    n_checks++; if (seen !== 1'b1) $display("[TB] FAIL busy restart_all_done got %0b expected 1", seen); else n_pass++;
    @(negedge clk);
    n_checks++; if (pass_cnt !== 2'd3) $display("[TB] FAIL busy restart_pass_cnt got %0d expected 3", pass_cnt); else n_pass++;
    n_checks++; if (fail_cnt !== 2'd0) $display("[TB] FAIL busy restart_fail_cnt got %0d expected 0", fail_cnt); else n_pass++;
  endtask

  initial begin
    reset     = 1'b1;
    go        = 1'b0;
    mode_list = '0;
    exp_sum   = '0;
    for (int i = 0; i < N_MAX * N_MAX; i++) dut_c[i*DATA_W +: DATA_W] = 12'd1;

    test_reset();
    test_nominal();
    test_mismatch();
    test_timeout();
    test_invalid_mode();
    test_busy_reset();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
